// File: rtl/micro_sequencer.sv
// Microprogram sequencer: computes the next control address (CAR) from a small op set.
// Optional return stack for CALL/RET is enabled by defining MICRO_SEQ_STACK_EN.
module micro_sequencer #(
  parameter int CAR_W     = 11,
  parameter int OP_W      = 7,
  parameter int NCOND     = 8,
  parameter int STK_DEPTH = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [2:0]                   NEXT_SEL,
  input  logic [CAR_W-1:0]             JADDR,
  input  logic [NCOND-1:0]             COND,
  input  logic [$clog2(NCOND)-1:0]     CSEL,
  input  logic                         CPOL,
  input  logic [OP_W-1:0]              OPCODE,
  input  logic                         MEM_REQ,
  input  logic                         MEM_RDY,
  output logic [CAR_W-1:0]             CAR,
  output logic                         STALL,
  output logic [$clog2(STK_DEPTH):0]   STK_LVL,
  output logic                         STK_ERR
);

  localparam int LVL_W = $clog2(STK_DEPTH) + 1;

  typedef enum logic [2:0] {
    OP_INC  = 3'b000,
    OP_JMP  = 3'b001,
    OP_CJMP = 3'b010,
    OP_MAP  = 3'b011,
    OP_CALL = 3'b100,
    OP_RET  = 3'b101,
    OP_HOLD = 3'b110,
    OP_ZERO = 3'b111
  } nextOp_e;

  logic [CAR_W-1:0] carQ, carD;
  logic [CAR_W-1:0] carInc;
  logic [CAR_W-1:0] mapAddr;
  logic             taken;

  assign STALL   = MEM_REQ & ~MEM_RDY;
  assign carInc  = carQ + CAR_W'(1);
  assign taken   = COND[CSEL] ^ CPOL;
  // Each opcode owns an aligned block of eight microwords.
  assign mapAddr = CAR_W'({OPCODE, 3'b000});
  assign CAR     = carQ;

`ifdef MICRO_SEQ_STACK_EN
  localparam int IDX_W = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;

  logic [CAR_W-1:0] stkQ [STK_DEPTH];
  logic [LVL_W-1:0] lvlQ, lvlD;
  logic             errQ, errD;
  logic             push;
  logic [IDX_W-1:0] pushIdx, popIdx;

  assign pushIdx = IDX_W'(lvlQ);
  assign popIdx  = IDX_W'(lvlQ - LVL_W'(1));
  assign STK_LVL = lvlQ;
  assign STK_ERR = errQ;

  // Stack entries carry no reset; occupancy alone decides what is valid.
  always_ff @(posedge CLK) begin
    if (push) begin
      stkQ[pushIdx] <= carInc;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      lvlQ <= '0;
      errQ <= 1'b0;
    end else begin
      lvlQ <= lvlD;
      errQ <= errD;
    end
  end
`else
  assign STK_LVL = '0;
  assign STK_ERR = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      carQ <= '0;
    end else begin
      carQ <= carD;
    end
  end

  always_comb begin
    carD = carQ;
`ifdef MICRO_SEQ_STACK_EN
    lvlD = lvlQ;
    errD = errQ;
    push = 1'b0;
`endif
    if (!STALL) begin
      case (nextOp_e'(NEXT_SEL))
        OP_INC:  carD = carInc;
        OP_JMP:  carD = JADDR;
        OP_CJMP: carD = taken ? JADDR : carInc;
        OP_MAP:  carD = mapAddr;
`ifdef MICRO_SEQ_STACK_EN
        OP_CALL: begin
          if (lvlQ == LVL_W'(STK_DEPTH)) begin
            errD = 1'b1;
            carD = carInc;
          end else begin
            push = 1'b1;
            lvlD = lvlQ + LVL_W'(1);
            carD = JADDR;
          end
        end
        OP_RET: begin
          if (lvlQ == '0) begin
            errD = 1'b1;
            carD = carInc;
          end else begin
            lvlD = lvlQ - LVL_W'(1);
            carD = stkQ[popIdx];
          end
        end
`else
        OP_CALL: carD = carInc;
        OP_RET:  carD = carInc;
`endif
        OP_HOLD: carD = carQ;
        OP_ZERO: carD = '0;
        default: carD = carQ;
      endcase
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: vector table, directed corner sequences,
// and randomized ops against a queue-based reference model.
module tb_micro_sequencer;

`ifdef MICRO_SEQ_STACK_EN
  localparam bit STK_EN = 1'b1;
`else
  localparam bit STK_EN = 1'b0;
`endif

  localparam logic [2:0] INC = 3'd0, JMP = 3'd1, CJMP = 3'd2, MAP = 3'd3;
  localparam logic [2:0] CALL = 3'd4, RET = 3'd5, HOLD = 3'd6, ZERO = 3'd7;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [2:0]  nextSel = '0;
  logic [10:0] jaddrS = '0;
  logic [7:0]  condS = '0;
  logic [2:0]  cselS = '0;
  logic        cpolS = 1'b0;
  logic [6:0]  opcodeS = '0;
  logic        memReq = 1'b0;
  logic        memRdy = 1'b0;
  logic [10:0] car;
  logic        stall;
  logic [2:0]  stkLvl;
  logic        stkErr;

  int total = 0;
  int bad = 0;

  int mCar;
  int mStk[$];
  bit mErr;

  micro_sequencer #(.CAR_W(11), .OP_W(7), .NCOND(8), .STK_DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .NEXT_SEL(nextSel), .JADDR(jaddrS), .COND(condS),
    .CSEL(cselS), .CPOL(cpolS), .OPCODE(opcodeS), .MEM_REQ(memReq), .MEM_RDY(memRdy),
    .CAR(car), .STALL(stall), .STK_LVL(stkLvl), .STK_ERR(stkErr)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string name, input int expCar, input int expLvl, input int expErr);
    checkOutput({name, ".car"}, int'(car), expCar);
    checkOutput({name, ".lvl"}, int'(stkLvl), expLvl);
    checkOutput({name, ".err"}, int'(stkErr), expErr);
  endtask

  // Reference behaviour: plain arithmetic on integers and a queue as the LIFO.
  task automatic modelStep(input logic [2:0] op, input int jaddr, input int cond, input int csel,
                           input bit cpol, input int opcode, input bit req, input bit rdy);
    int nxt;
    if (req && !rdy) return;
    nxt = (mCar + 1) % 2048;
    case (op)
      INC:  mCar = nxt;
      JMP:  mCar = jaddr;
      CJMP: mCar = ((((cond >> csel) & 1) != 0) != cpol) ? jaddr : nxt;
      MAP:  mCar = opcode * 8;
      CALL: begin
        if (!STK_EN) mCar = nxt;
        else if (mStk.size() == 4) begin mErr = 1'b1; mCar = nxt; end
        else begin mStk.push_back(nxt); mCar = jaddr; end
      end
      RET: begin
        if (!STK_EN) mCar = nxt;
        else if (mStk.size() == 0) begin mErr = 1'b1; mCar = nxt; end
        else mCar = mStk.pop_back();
      end
      HOLD: mCar = mCar;
      default: mCar = 0;
    endcase
  endtask

  task automatic applyStimulus(input logic [2:0] op, input int jaddr, input int cond, input int csel,
                               input bit cpol, input int opcode, input bit req, input bit rdy);
    nextSel = op;
    jaddrS  = 11'(jaddr);
    condS   = 8'(cond);
    cselS   = 3'(csel);
    cpolS   = cpol;
    opcodeS = 7'(opcode);
    memReq  = req;
    memRdy  = rdy;
    #1;
    checkOutput("stall", int'(stall), int'(req && !rdy));
    @(posedge CLK);
    modelStep(op, jaddr, cond, csel, cpol, opcode, req, rdy);
    #1;
  endtask

  task automatic simpleOp(input logic [2:0] op, input int jaddr);
    applyStimulus(op, jaddr, 0, 0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  // Asserts reset between edges and checks it takes effect without a clock edge.
  task automatic doReset();
    RST = 1'b0;
    #1;
    checkAll("reset", 0, 0, 0);
    mCar = 0;
    mStk.delete();
    mErr = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b1;
  endtask

  typedef struct {
    logic [2:0] op;
    int jaddr;
    int cond;
    int csel;
    bit cpol;
    int opcode;
    bit req;
    bit rdy;
    int expCar;
  } vec_t;

  vec_t vecs[$];
  vec_t v;

  initial begin
    vecs.push_back('{INC,  0,     0,    0, 1'b0, 0,    1'b0, 1'b0, 'h001});
    vecs.push_back('{INC,  0,     0,    0, 1'b0, 0,    1'b0, 1'b0, 'h002});
    vecs.push_back('{INC,  0,     0,    0, 1'b0, 0,    1'b0, 1'b0, 'h003});
    vecs.push_back('{JMP,  'h7FF, 0,    0, 1'b0, 0,    1'b0, 1'b0, 'h7FF});
    vecs.push_back('{INC,  0,     0,    0, 1'b0, 0,    1'b0, 1'b0, 'h000});
    vecs.push_back('{MAP,  0,     0,    0, 1'b0, 'h05, 1'b0, 1'b0, 'h028});
    vecs.push_back('{MAP,  0,     0,    0, 1'b0, 'h7F, 1'b0, 1'b0, 'h3F8});
    vecs.push_back('{CJMP, 'h100, 'h04, 2, 1'b0, 0,    1'b0, 1'b0, 'h100});
    vecs.push_back('{CJMP, 'h100, 'h00, 2, 1'b0, 0,    1'b0, 1'b0, 'h101});
    vecs.push_back('{CJMP, 'h050, 'h00, 2, 1'b1, 0,    1'b0, 1'b0, 'h050});
    vecs.push_back('{CJMP, 'h060, 'h80, 7, 1'b1, 0,    1'b0, 1'b0, 'h051});
    vecs.push_back('{HOLD, 'h222, 0,    0, 1'b0, 0,    1'b0, 1'b0, 'h051});
    vecs.push_back('{ZERO, 'h222, 0,    0, 1'b0, 0,    1'b0, 1'b0, 'h000});
    vecs.push_back('{JMP,  'h123, 0,    0, 1'b0, 0,    1'b1, 1'b0, 'h000});
    vecs.push_back('{JMP,  'h123, 0,    0, 1'b0, 0,    1'b1, 1'b1, 'h123});
    vecs.push_back('{INC,  0,     0,    0, 1'b0, 0,    1'b0, 1'b1, 'h124});

    #2;
    doReset();

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      applyStimulus(v.op, v.jaddr, v.cond, v.csel, v.cpol, v.opcode, v.req, v.rdy);
      checkAll($sformatf("vec%0d", i), v.expCar, 0, 0);
    end

    // Call/return round trip; without the stack both ops degrade to INC.
    simpleOp(JMP, 'h010);
    checkAll("callSetup", 'h010, 0, 0);
    simpleOp(CALL, 'h200);
    checkAll("call", STK_EN ? 'h200 : 'h011, STK_EN ? 1 : 0, 0);
    simpleOp(INC, 0);
    checkAll("callInc", STK_EN ? 'h201 : 'h012, STK_EN ? 1 : 0, 0);
    simpleOp(RET, 0);
    checkAll("ret", STK_EN ? 'h011 : 'h013, 0, 0);

    // Overflow on the fifth nested call, then drain and underflow.
    simpleOp(ZERO, 0);
    for (int i = 1; i <= 4; i++) begin
      simpleOp(CALL, i * 'h100);
      checkAll($sformatf("nest%0d", i), STK_EN ? i * 'h100 : i, STK_EN ? i : 0, 0);
    end
    simpleOp(CALL, 'h500);
    checkAll("overflow", STK_EN ? 'h401 : 5, STK_EN ? 4 : 0, STK_EN ? 1 : 0);
    for (int i = 3; i >= 0; i--) begin
      simpleOp(RET, 0);
      checkAll($sformatf("pop%0d", i), STK_EN ? i * 'h100 + 1 : 9 - i, STK_EN ? i : 0, STK_EN ? 1 : 0);
    end
    simpleOp(RET, 0);
    checkAll("underflow", STK_EN ? 'h002 : 'h00A, 0, STK_EN ? 1 : 0);

    // Memory stall freezes CAR for three cycles, then the jump lands.
    doReset();
    simpleOp(JMP, 'h040);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(JMP, 'h300, 0, 0, 1'b0, 0, 1'b1, 1'b0);
      checkAll($sformatf("stall%0d", i), 'h040, 0, 0);
    end
    applyStimulus(JMP, 'h300, 0, 0, 1'b0, 0, 1'b1, 1'b1);
    checkAll("stallDone", 'h300, 0, 0);

    // Reset in the middle of a call chain discards every return address.
    simpleOp(CALL, 'h100);
    simpleOp(CALL, 'h200);
    checkAll("chain", STK_EN ? 'h200 : 'h302, STK_EN ? 2 : 0, 0);
    doReset();
    simpleOp(INC, 0);
    checkAll("postRst", 1, 0, 0);
    simpleOp(RET, 0);
    checkAll("postRstRet", 2, 0, STK_EN ? 1 : 0);

    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 0) doReset();
      applyStimulus(3'($urandom_range(0, 7)), int'($urandom_range(0, 2047)),
                    int'($urandom_range(0, 255)), int'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 127)),
                    ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      checkAll($sformatf("rnd%0d", i), mCar, mStk.size(), int'(mErr));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
